// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types and constants for paced audio-stream blocks.
//                pacer_state_t is the playback state of a rate pacer.
//                AUDIO_RATE_* are common output sample rates in Hz.
//                AUDIO_SAMPLE_W is the signed PCM sample width.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FADE = 2'd2
  } pacer_state_t;

  localparam int AUDIO_RATE_37K8 = 37800;
  localparam int AUDIO_RATE_18K9 = 18900;
  localparam int AUDIO_SAMPLE_W  = 16;

endpackage
`default_nettype wire

// File: rtl/audio_rate_pacer_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_rate_pacer_if
//  Description : Audio-stream link between a sample FIFO and its consumer.
//                sample : signed PCM word at the FIFO head
//                write  : FIFO has a sample available (valid)
//                strobe : consumer takes the head sample this cycle
//                master = FIFO side, slave = consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface audio_rate_pacer_if;
  import audio_pkg::*;

  logic signed [AUDIO_SAMPLE_W-1:0] sample;
  logic                             write;
  logic                             strobe;

  modport master (output sample, output write, input strobe);
  modport slave  (input sample, input write, output strobe);

endinterface
`default_nettype wire

// File: rtl/audio_rate_nco.sv
`default_nettype none
// ============================================================================
//  Module      : audio_rate_nco
//  Description : Fractional divider producing rate_hz one-cycle ticks per
//                CLK_HZ clock cycles. The phase accumulator is never cleared
//                on a rate change, so retuning does not glitch.
//                clk     : system clock
//                reset_n : asynchronous reset, active low
//                rate_hz : tick rate in Hz, must be below CLK_HZ
//                tick    : registered one-cycle pulse
//  Revision    : 1.0  initial release
// ============================================================================
module audio_rate_nco #(
  parameter int CLK_HZ = 30000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] rate_hz,
  output logic        tick
);

  localparam int              ACC_W   = 32;
  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, sum_w;
  logic             tick_q, tick_d;

  // acc stays below MODULUS and rate_hz is below MODULUS, so sum_w cannot wrap.
  always_comb begin
    sum_w = acc_q + {{(ACC_W-17){1'b0}}, rate_hz};
    if (sum_w >= MODULUS) begin
      acc_d  = sum_w - MODULUS;
      tick_d = 1'b1;
    end else begin
      acc_d  = sum_w;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/audio_rate_pacer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_rate_pacer
//  Description : Drains an audio FIFO at a programmable sample rate, holding
//                one sample per output tick. On starvation it holds the last
//                sample, then halves it toward zero and parks idle.
//                clk/reset_n    : system clock, async active-low reset
//                in             : audio-stream sink (sample, write, strobe)
//                enable         : 1 = play, 0 = fade out and idle
//                rate_hz        : output sample rate in Hz
//                sample_out     : current signed output sample
//                sample_valid   : pulse, sample_out refreshed
//                underrun       : sticky starved-tick flag
//                underrun_count : saturating starved-tick count
//                clr_underrun   : clears underrun flag and count
//  Revision    : 1.0  initial release
// ============================================================================
module audio_rate_pacer
  import audio_pkg::*;
#(
  parameter int CLK_HZ         = 30000000,
  parameter int UNDERRUN_LIMIT = 4,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  audio_rate_pacer_if.slave                in,
  input  logic                             enable,
  input  logic [16:0]                      rate_hz,
  output logic signed [AUDIO_SAMPLE_W-1:0] sample_out,
  output logic                             sample_valid,
  output logic                             underrun,
  output logic [CNT_W-1:0]                 underrun_count,
  input  logic                             clr_underrun
);

  localparam int               MISS_W    = $clog2(UNDERRUN_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNDERRUN_LIMIT - 1);

  pacer_state_t                     state_q, state_d;
  logic signed [AUDIO_SAMPLE_W-1:0] sample_q, sample_d;
  logic                             valid_q, valid_d;
  logic                             underrun_q, underrun_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [MISS_W-1:0]                miss_q, miss_d;

  logic                             tick_w;
  logic                             consume_w;
  logic                             starved_w;
  logic signed [AUDIO_SAMPLE_W-1:0] adj_w;
  logic signed [AUDIO_SAMPLE_W-1:0] fade_w;

  audio_rate_nco #(
    .CLK_HZ (CLK_HZ)
  ) u_nco (
    .clk     (clk),
    .reset_n (reset_n),
    .rate_hz (rate_hz),
    .tick    (tick_w)
  );

  // RUN keeps consuming even while enable is dropping so an in-flight
  // transfer completes; IDLE and FADE only take data when playing.
  assign consume_w = tick_w && in.write && ((state_q == RUN) || enable);
  assign in.strobe = consume_w;

  // Adding 1 to negatives before the arithmetic shift rounds toward zero,
  // so -1 reaches 0 instead of sticking.
  assign adj_w  = sample_q + AUDIO_SAMPLE_W'(sample_q[AUDIO_SAMPLE_W-1]);
  assign fade_w = adj_w >>> 1;

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    miss_d     = miss_q;
    underrun_d = underrun_q;
    count_d    = count_q;
    starved_w  = 1'b0;

    case (state_q)
      IDLE: begin
        if (consume_w) begin
          sample_d = in.sample;
          valid_d  = 1'b1;
          miss_d   = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (tick_w) begin
          valid_d = 1'b1;
          if (consume_w) begin
            sample_d = in.sample;
            miss_d   = '0;
          end else begin
            starved_w = 1'b1;
            miss_d    = miss_q + MISS_W'(1);
            if (miss_q == MISS_LAST) state_d = FADE;
          end
        end
        if (!enable) state_d = FADE;
      end

      FADE: begin
        if (tick_w) begin
          if (consume_w) begin
            sample_d = in.sample;
            valid_d  = 1'b1;
            miss_d   = '0;
            state_d  = RUN;
          end else begin
            // A deliberate stop (enable low) is not an underrun.
            starved_w = enable;
            if (sample_q == '0) begin
              state_d = IDLE;
            end else begin
              sample_d = fade_w;
              valid_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (starved_w) begin
      underrun_d = 1'b1;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end
    if (clr_underrun) begin
      underrun_d = 1'b0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      count_q    <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
      miss_q     <= miss_d;
    end
  end

  assign sample_out     = sample_q;
  assign sample_valid   = valid_q;
  assign underrun       = underrun_q;
  assign underrun_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_rate_pacer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_rate_pacer
//  Description : Self-checking bench for audio_rate_pacer. A queue-based FIFO
//                feeds the stream; a behavioural model predicts every output
//                refresh into a scoreboard that a monitor pops on
//                sample_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_rate_pacer;

  localparam int CLK     = 100;
  localparam int LIMIT   = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FADE  = 2;

  typedef struct {
    int s;
    int ur;
    int cnt;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [16:0]       rate_hz;
  logic signed [15:0] sample_out;
  logic              sample_valid;
  logic              underrun;
  logic [CW-1:0]     underrun_count;
  logic              clr_underrun;

  audio_rate_pacer_if ifc ();

  audio_rate_pacer #(
    .CLK_HZ         (CLK),
    .UNDERRUN_LIMIT (LIMIT),
    .CNT_W          (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in             (ifc),
    .enable         (enable),
    .rate_hz        (rate_hz),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .clr_underrun   (clr_underrun)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   fifo[$];
  exp_t exp_q[$];
  int   seen[$];
  bit   pop_pend = 0;

  // behavioural model state
  int m_state = S_IDLE, m_acc = 0, m_tick = 0, m_out = 0, m_miss = 0, m_ur = 0, m_cnt = 0;
  int m_ns, m_nout, m_nt, m_push, m_starve;
  bit es;
  exp_t e_tmp, e_got;

  // strobe window statistics
  bit win_on = 0;
  int win_cnt = 0, last_st = -1, spc_lo = 0, spc_hi = 0, cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic drive_bus();
    ifc.write  = (fifo.size() != 0);
    ifc.sample = (fifo.size() != 0) ? 16'(fifo[0]) : 16'sd0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_model(input int s, input int budget, input string name);
    int n = 0;
    while (m_state != s && n < budget) begin
      step(1);
      n++;
    end
    if (m_state != s) timeout_fail(name);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO pop lands just after the edge on which the DUT captured the head.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      if (fifo.size() != 0) fifo.delete(0);
      pop_pend = 0;
    end
    drive_bus();
  end

  // Monitor + reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_state = S_IDLE; m_acc = 0; m_tick = 0; m_out = 0;
      m_miss = 0; m_ur = 0; m_cnt = 0;
      pop_pend = 0;
      exp_q.delete();
    end else begin
      if (sample_valid) begin
        seen.push_back(int'(sample_out));
        if (exp_q.size() == 0) begin
          check("unexpected_sample_valid", 1, 0);
        end else begin
          e_got = exp_q.pop_front();
          check("sample_out", sample_out, e_got.s);
          check("underrun", underrun, e_got.ur);
          check("underrun_count", underrun_count, e_got.cnt);
        end
      end else if (exp_q.size() != 0) begin
        check("sample_valid", 0, 1);
        exp_q.delete();
      end

      es = (m_tick != 0) && ifc.write && (m_state == S_RUN || enable);
      check("strobe", ifc.strobe, es);

      if (win_on && ifc.strobe) begin
        win_cnt++;
        if (last_st >= 0) begin
          n_tests++;
          if ((cyc - last_st) < spc_lo || (cyc - last_st) > spc_hi) begin
            n_fail++;
            $display("FAIL strobe_spacing: got %0d, expected %0d..%0d", cyc - last_st, spc_lo, spc_hi);
          end
        end
        last_st = cyc;
      end

      // rate_hz ticks per CLK cycles: emit a tick whenever the running phase wraps
      m_nt = 0;
      if (m_acc + int'(rate_hz) >= CLK) begin
        m_acc = m_acc + int'(rate_hz) - CLK;
        m_nt  = 1;
      end else begin
        m_acc = m_acc + int'(rate_hz);
      end

      m_ns = m_state; m_nout = m_out; m_push = 0; m_starve = 0;
      if (m_state == S_IDLE) begin
        if (es) begin m_nout = int'(ifc.sample); m_push = 1; m_miss = 0; m_ns = S_RUN; end
      end else if (m_state == S_RUN) begin
        if (m_tick != 0) begin
          m_push = 1;
          if (es) begin
            m_nout = int'(ifc.sample); m_miss = 0;
          end else begin
            m_starve = 1; m_miss++;
            if (m_miss >= LIMIT) m_ns = S_FADE;
          end
        end
        if (!enable) m_ns = S_FADE;
      end else begin
        if (m_tick != 0) begin
          if (es) begin
            m_nout = int'(ifc.sample); m_push = 1; m_miss = 0; m_ns = S_RUN;
          end else begin
            m_starve = enable ? 1 : 0;
            if (m_out == 0) m_ns = S_IDLE;
            else begin m_nout = m_out / 2; m_push = 1; end
          end
        end
      end

      if (clr_underrun) begin
        m_ur = 0; m_cnt = 0;
      end else if (m_starve != 0) begin
        m_ur = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end

      if (m_push != 0) begin
        e_tmp.s = m_nout; e_tmp.ur = m_ur; e_tmp.cnt = m_cnt;
        exp_q.push_back(e_tmp);
      end
      pop_pend = es;
      m_state = m_ns; m_out = m_nout; m_tick = m_nt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fade_tab[15];
    int neg_tab[7];
    int n;
    fade_tab = '{1000, 1000, 1000, 1000, 1000, 500, 250, 125, 62, 31, 15, 7, 3, 1, 0};
    neg_tab  = '{-3, -3, -3, -3, -3, -1, 0};

    reset_n = 1'b0; enable = 1'b0; rate_hz = '0; clr_underrun = 1'b0;
    drive_bus();
    step(2);
    check("reset_sample_out", sample_out, 0);
    check("reset_sample_valid", sample_valid, 0);
    check("reset_underrun", underrun, 0);
    check("reset_count", underrun_count, 0);
    check("reset_strobe", ifc.strobe, 0);

    // Prefilled FIFO 1,2,3... at rate 25: one strobe every 4 clocks.
    for (int i = 1; i <= 40; i++) fifo.push_back(i);
    rate_hz = 17'd25; enable = 1'b1;
    drive_bus();
    step(1);
    reset_n = 1'b1;
    wait_model(S_RUN, 20, "wait_first_run");
    win_cnt = 0; last_st = -1; spc_lo = 4; spc_hi = 4; win_on = 1;
    step(100);
    win_on = 0;
    check("strobes_in_100_at_25", win_cnt, 25);
    check("first_samples_1", seen[0], 1);
    check("first_samples_2", seen[1], 2);
    check("first_samples_3", seen[2], 3);

    // Rate 30 for 1000 clocks, then drain ending in 1000.
    for (int i = 0; i < 320; i++) fifo.push_back(int'($urandom_range(0, 65535)) - 32768);
    fifo.push_back(1000);
    drive_bus();
    rate_hz = 17'd30;
    step(2);
    win_cnt = 0; last_st = -1; spc_lo = 3; spc_hi = 4; win_on = 1;
    step(1000);
    win_on = 0;
    check("ticks_in_1000_at_30", win_cnt, 300);

    wait_model(S_IDLE, 600, "wait_fade_1000");
    step(2);
    n = seen.size();
    for (int i = 0; i < 15; i++) check("fade_1000_seq", seen[n-15+i], fade_tab[i]);
    check("fade_idle_out", sample_out, 0);
    check("fade_underrun", underrun, 1);
    check("fade_count", underrun_count, 15);

    // Second starvation episode: count must stay saturated.
    fifo.push_back(1000); drive_bus();
    wait_model(S_RUN, 20, "wait_refill_run");
    wait_model(S_IDLE, 300, "wait_fade_again");
    step(2);
    check("count_saturated", underrun_count, CNT_MAX);
    check("underrun_sticky", underrun, 1);

    // clr_underrun coinciding with a starved tick.
    fifo.push_back(500); drive_bus();
    wait_model(S_RUN, 20, "wait_run_clr");
    n = 0;
    while (!(m_tick != 0 && m_state == S_RUN && !ifc.write) && n < 50) begin step(1); n++; end
    if (n >= 50) timeout_fail("wait_starved_tick");
    clr_underrun = 1'b1;
    step(1);
    clr_underrun = 1'b0;
    check("clr_underrun_flag", underrun, 0);
    check("clr_underrun_count", underrun_count, 0);
    wait_model(S_IDLE, 300, "wait_fade_500");

    // Negative fade must reach zero.
    fifo.push_back(-3); drive_bus();
    wait_model(S_RUN, 20, "wait_run_neg");
    wait_model(S_IDLE, 200, "wait_fade_neg");
    step(2);
    n = seen.size();
    for (int i = 0; i < 7; i++) check("fade_neg_seq", seen[n-7+i], neg_tab[i]);
    check("neg_idle_out", sample_out, 0);

    // Disable mid-run: fade without counting underruns.
    clr_underrun = 1'b1; step(1); clr_underrun = 1'b0;
    for (int i = 0; i < 12; i++) fifo.push_back(int'($urandom_range(0, 65535)) - 32768);
    drive_bus();
    wait_model(S_RUN, 20, "wait_run_dis");
    step(10);
    enable = 1'b0;
    wait_model(S_IDLE, 400, "wait_idle_dis");
    step(2);
    check("disable_no_underrun", underrun, 0);
    check("disable_count", underrun_count, 0);
    check("disable_out", sample_out, 0);
    enable = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0 && fifo.size() < 8) begin
        fifo.push_back(int'($urandom_range(0, 65535)) - 32768);
        drive_bus();
      end
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      clr_underrun = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) rate_hz = 17'($urandom_range(0, 99));
      step(1);
    end
    clr_underrun = 1'b0;

    // Async reset mid-run, asserted while a strobe is active.
    enable = 1'b1; rate_hz = 17'd25;
    for (int i = 0; i < 10; i++) fifo.push_back(100 + i);
    drive_bus();
    wait_model(S_RUN, 400, "wait_run_rst");
    n = 0;
    while (!(m_tick != 0 && ifc.write) && n < 50) begin step(1); n++; end
    if (n >= 50) timeout_fail("wait_strobe_rst");
    reset_n = 1'b0;
    #1;
    check("rst_strobe", ifc.strobe, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_count", underrun_count, 0);
    step(3);
    reset_n = 1'b1;
    wait_model(S_RUN, 40, "wait_run_after_rst");
    enable = 1'b0;
    wait_model(S_IDLE, 400, "wait_final_idle");
    step(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
